// File: rtl/kasumi_pkg.sv
// Shared definitions for the pipeline controller: FSM state codes,
// bit positions inside ex_mem_command, and execute command codes.
package kasumi_pkg;

  // Controller FSM states; code 3 is never entered on purpose and decodes as RUN
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;
  localparam logic [1:0] ST_UNUSED   = 2'd3;

  // Field positions inside ex_mem_command
  localparam int MEMCMD_ACCESS = 0;
  localparam int MEMCMD_WRITE  = 1;
  localparam int MEMCMD_F3_LSB = 2;
  localparam int MEMCMD_F3_MSB = 4;

  // Execute command codes, shared with the execute stage
  typedef enum logic [2:0] {
    EXCMD_ALU    = 3'd0,
    EXCMD_BRANCH = 3'd1,
    EXCMD_JAL    = 3'd2,
    EXCMD_JALR   = 3'd3,
    EXCMD_FENCE  = 3'd4,
    EXCMD_LOAD   = 3'd5,
    EXCMD_STORE  = 3'd6
  } ex_command_e;

  // A memory command is a load when it accesses memory without writing
  function automatic logic is_load(input logic access, input logic write_en);
    return access & ~write_en;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: the EX instruction is a load whose destination
// (other than x0) is read by the instruction currently in ID.
module hazard_detect
  import kasumi_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_reg_d,
  input  logic       ex_mem_access,
  input  logic       ex_mem_write,
  output logic       load_use
);

  logic [4:0] src_reg [2];
  logic [1:0] src_use;
  logic [1:0] src_hit;

  assign src_reg[0] = id_rs1;
  assign src_reg[1] = id_rs2;
  assign src_use    = {id_use_rs2, id_use_rs1};

  // One comparator per source operand
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] & (src_reg[gi] == ex_reg_d);
    end
  endgenerate

  assign load_use = is_load(ex_mem_access, ex_mem_write) & (ex_reg_d != 5'd0) & (|src_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: produces the
// per-stage stop/bubble controls for load-use stalls, execute redirects and
// data-memory wait states (with timeout fault).
module pipeline_ctrl
  import kasumi_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_reg_d,
  input  logic [4:0]  ex_mem_command,
  input  logic        ex_wb_pc,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        ext_stop,
  output logic        if_stop,
  output logic        id_stop,
  output logic        ex_stop,
  output logic        mem_stop,
  output logic        wb_stop,
  output logic        if_bubble,
  output logic        id_bubble,
  output logic        ex_bubble,
  output logic        mem_fault,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_count
);

  logic [1:0]  state_reg, state_next;
  logic [1:0]  flush_cnt_reg, flush_cnt_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        fault_reg, fault_next;
  logic [31:0] stall_cnt_reg;

  logic        load_use;
  logic        in_wait;
  logic        in_flush;
  logic        wait_active;
  logic [8:0]  wait_calc;
  logic        stop_all_c, if_stop_c, id_stop_c;
  logic        if_bubble_c, id_bubble_c, ex_bubble_c;
  logic        any_stop;
  logic [2:0]  f3_unused;

  // funct3 bits are carried for the memory stage; the controller ignores them
  assign f3_unused = ex_mem_command[MEMCMD_F3_MSB:MEMCMD_F3_LSB];

  hazard_detect u_hazard_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_reg_d      (ex_reg_d),
    .ex_mem_access (ex_mem_command[MEMCMD_ACCESS]),
    .ex_mem_write  (ex_mem_command[MEMCMD_WRITE]),
    .load_use      (load_use)
  );

  assign in_wait  = (state_reg == ST_MEM_WAIT);
  assign in_flush = (state_reg == ST_FLUSH);
  // Once waiting, only mem_ready ends the wait; from RUN/FLUSH a new wait needs mem_req
  assign wait_active = in_wait ? ~mem_ready : (mem_req & ~mem_ready);
  assign wait_calc   = in_wait ? ({1'b0, wait_cnt_reg} + 9'd1) : 9'd1;

  // Next-state and control decode in priority order: ext_stop, wait, redirect, flush, load-use
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    fault_next     = 1'b0;
    stop_all_c     = 1'b0;
    if_stop_c      = 1'b0;
    id_stop_c      = 1'b0;
    if_bubble_c    = 1'b0;
    id_bubble_c    = 1'b0;
    ex_bubble_c    = 1'b0;
    if (ext_stop) begin
      stop_all_c = 1'b1;
    end else if (wait_active) begin
      stop_all_c = 1'b1;
      if (wait_calc >= 9'(MEM_TIMEOUT)) begin
        fault_next    = 1'b1;
        state_next    = ST_RUN;
        wait_cnt_next = 8'd0;
      end else begin
        state_next    = ST_MEM_WAIT;
        wait_cnt_next = wait_calc[7:0];
      end
    end else begin
      // Wait exit and the unused code both fall through to RUN behaviour
      state_next    = ST_RUN;
      wait_cnt_next = 8'd0;
      if (ex_wb_pc) begin
        if_bubble_c = 1'b1;
        id_bubble_c = 1'b1;
        if (FLUSH_CYCLES != 0) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = 2'(FLUSH_CYCLES);
        end
      end else if (in_flush) begin
        id_bubble_c = 1'b1;
        if (flush_cnt_reg <= 2'd1) begin
          flush_cnt_next = 2'd0;
        end else begin
          state_next     = ST_FLUSH;
          flush_cnt_next = flush_cnt_reg - 2'd1;
        end
      end else if (load_use) begin
        if_stop_c   = 1'b1;
        id_stop_c   = 1'b1;
        ex_bubble_c = 1'b1;
      end
    end
  end

  // Stage controls are forced low while reset is held
  assign if_stop   = rst_n & (stop_all_c | if_stop_c);
  assign id_stop   = rst_n & (stop_all_c | id_stop_c);
  assign ex_stop   = rst_n & stop_all_c;
  assign mem_stop  = rst_n & stop_all_c;
  assign wb_stop   = rst_n & stop_all_c;
  assign if_bubble = rst_n & if_bubble_c;
  assign id_bubble = rst_n & id_bubble_c;
  assign ex_bubble = rst_n & ex_bubble_c;
  assign any_stop  = stop_all_c | if_stop_c | id_stop_c;

  // FSM state, counters and fault pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= 2'd0;
      wait_cnt_reg  <= 8'd0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      fault_reg     <= fault_next;
    end
  end

  // Saturating count of cycles with any stage held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= 32'd0;
    end else if (any_stop && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign mem_fault   = fault_reg;
  assign ctrl_state  = state_reg;
  assign stall_count = stall_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl (FLUSH_CYCLES = 1, MEM_TIMEOUT = 4): directed
// vectors with literal expectations plus a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int FC = 1;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_reg_d, ex_mem_command;
  logic        id_use_rs1, id_use_rs2, ex_wb_pc, mem_req, mem_ready, ext_stop;
  logic        if_stop, id_stop, ex_stop, mem_stop, wb_stop;
  logic        if_bubble, id_bubble, ex_bubble, mem_fault;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_reg_d(ex_reg_d), .ex_mem_command(ex_mem_command), .ex_wb_pc(ex_wb_pc),
    .mem_req(mem_req), .mem_ready(mem_ready), .ext_stop(ext_stop),
    .if_stop(if_stop), .id_stop(id_stop), .ex_stop(ex_stop), .mem_stop(mem_stop), .wb_stop(wb_stop),
    .if_bubble(if_bubble), .id_bubble(id_bubble), .ex_bubble(ex_bubble),
    .mem_fault(mem_fault), .ctrl_state(ctrl_state), .stall_count(stall_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_reg_d = 0; ex_mem_command = 0; ex_wb_pc = 0;
    mem_req = 0; mem_ready = 0; ext_stop = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: whether a memory wait is open and how long it has run,
  // how many ID-squash cycles remain after a redirect, the pending fault
  // pulse, and the number of held cycles so far.
  bit m_waiting;
  int m_waited;
  int m_flush_left;
  bit m_fault;
  int m_stalls;
  bit lu, wact;
  bit e_ifs, e_ids, e_all, e_ifb, e_idb, e_exb;
  int e_state;

  // Compare on every falling edge, then advance the model past the next rising edge
  always @(negedge clk) begin
    e_ifs = 0; e_ids = 0; e_all = 0; e_ifb = 0; e_idb = 0; e_exb = 0;
    if (!rst_n) begin
      m_waiting = 0; m_waited = 0; m_flush_left = 0; m_fault = 0; m_stalls = 0;
      check("rst_state", {30'd0, ctrl_state}, 0);
      check("rst_stall_count", stall_count, 0);
      check("rst_fault", {31'd0, mem_fault}, 0);
    end else begin
      e_state = m_waiting ? 2 : (m_flush_left > 0 ? 1 : 0);
      check("m_ctrl_state", {30'd0, ctrl_state}, e_state);
      check("m_stall_count", stall_count, m_stalls);
      check("m_mem_fault", {31'd0, mem_fault}, {31'd0, m_fault});
      lu = ex_mem_command[0] && !ex_mem_command[1] && (ex_reg_d != 0) &&
           ((id_use_rs1 && id_rs1 == ex_reg_d) || (id_use_rs2 && id_rs2 == ex_reg_d));
      wact = m_waiting ? !mem_ready : (mem_req && !mem_ready);
      m_fault = 0;
      if (ext_stop) begin
        e_all = 1;
      end else if (wact) begin
        e_all = 1;
        m_waited = m_waiting ? m_waited + 1 : 1;
        m_flush_left = 0;
        if (m_waited >= TO) begin
          m_fault = 1; m_waiting = 0; m_waited = 0;
        end else begin
          m_waiting = 1;
        end
      end else begin
        m_waiting = 0; m_waited = 0;
        if (ex_wb_pc) begin
          e_ifb = 1; e_idb = 1; m_flush_left = FC;
        end else if (m_flush_left > 0) begin
          e_idb = 1; m_flush_left--;
        end else if (lu) begin
          e_ifs = 1; e_ids = 1; e_exb = 1;
        end
      end
      if (e_all || e_ifs || e_ids) m_stalls++;
    end
    check("m_if_stop",   {31'd0, if_stop},   {31'd0, e_all | e_ifs});
    check("m_id_stop",   {31'd0, id_stop},   {31'd0, e_all | e_ids});
    check("m_ex_stop",   {31'd0, ex_stop},   {31'd0, e_all});
    check("m_mem_stop",  {31'd0, mem_stop},  {31'd0, e_all});
    check("m_wb_stop",   {31'd0, wb_stop},   {31'd0, e_all});
    check("m_if_bubble", {31'd0, if_bubble}, {31'd0, e_ifb});
    check("m_id_bubble", {31'd0, id_bubble}, {31'd0, e_idb});
    check("m_ex_bubble", {31'd0, ex_bubble}, {31'd0, e_exb});
  end

  initial begin
    clear_in();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    $display("reset: state=%0d stall_count=%0d", ctrl_state, stall_count);
    check("reset_state", {30'd0, ctrl_state}, 0);
    check("reset_stall_count", stall_count, 0);
    check("reset_if_stop", {31'd0, if_stop}, 0);
    check("reset_fault", {31'd0, mem_fault}, 0);
    rst_n = 1'b1;
    tick();

    // Load-use: lw x5 in EX, ID reads x5 through rs1
    ex_mem_command = 5'b01001; ex_reg_d = 5; id_rs1 = 5; id_use_rs1 = 1; #1;
    $display("load-use rs1: if_stop=%0b id_stop=%0b ex_bubble=%0b", if_stop, id_stop, ex_bubble);
    check("lu_if_stop", {31'd0, if_stop}, 1);
    check("lu_id_stop", {31'd0, id_stop}, 1);
    check("lu_ex_bubble", {31'd0, ex_bubble}, 1);
    check("lu_ex_stop", {31'd0, ex_stop}, 0);
    tick();
    clear_in(); #1;
    $display("load-use next cycle: id_stop=%0b stall_count=%0d", id_stop, stall_count);
    check("lu_once", {31'd0, id_stop}, 0);
    check("lu_stall_count", stall_count, 1);
    tick();

    // Load to x0 never stalls
    ex_mem_command = 5'b01001; ex_reg_d = 0; id_rs1 = 0; id_use_rs1 = 1; #1;
    $display("load x0: id_stop=%0b", id_stop);
    check("lu_x0", {31'd0, id_stop}, 0);
    tick();
    // Matching register but rs1 not read
    ex_reg_d = 5; id_rs1 = 5; id_use_rs1 = 0; #1;
    $display("rs1 unused: id_stop=%0b", id_stop);
    check("lu_unused", {31'd0, id_stop}, 0);
    tick();
    // Store is not a load
    ex_mem_command = 5'b01011; id_use_rs1 = 1; #1;
    $display("store: id_stop=%0b", id_stop);
    check("lu_store", {31'd0, id_stop}, 0);
    tick();
    // Hit through rs2
    ex_mem_command = 5'b01001; id_use_rs1 = 0; id_rs1 = 0; id_rs2 = 5; id_use_rs2 = 1; #1;
    $display("load-use rs2: id_stop=%0b", id_stop);
    check("lu_rs2", {31'd0, id_stop}, 1);
    tick();
    clear_in(); tick();

    // Redirect pulse
    ex_wb_pc = 1; #1;
    $display("redirect c0: if_bubble=%0b id_bubble=%0b", if_bubble, id_bubble);
    check("rd_c0_if_bubble", {31'd0, if_bubble}, 1);
    check("rd_c0_id_bubble", {31'd0, id_bubble}, 1);
    tick();
    ex_wb_pc = 0; #1;
    $display("redirect c1: state=%0d id_bubble=%0b", ctrl_state, id_bubble);
    check("rd_c1_state", {30'd0, ctrl_state}, 1);
    check("rd_c1_id_bubble", {31'd0, id_bubble}, 1);
    check("rd_c1_if_bubble", {31'd0, if_bubble}, 0);
    tick(); #1;
    $display("redirect c2: state=%0d id_bubble=%0b", ctrl_state, id_bubble);
    check("rd_c2_state", {30'd0, ctrl_state}, 0);
    check("rd_c2_id_bubble", {31'd0, id_bubble}, 0);
    tick();

    // Memory wait of 3 cycles
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      $display("mem wait %0d: wb_stop=%0b state=%0d", i, wb_stop, ctrl_state);
      check("mw_wb_stop", {31'd0, wb_stop}, 1);
      tick();
    end
    mem_ready = 1; #1;
    $display("mem ready: state=%0d stall_count=%0d if_stop=%0b", ctrl_state, stall_count, if_stop);
    check("mw_state", {30'd0, ctrl_state}, 2);
    check("mw_stall_count", stall_count, 5);
    check("mw_release", {31'd0, if_stop}, 0);
    tick();
    clear_in(); #1;
    check("mw_run", {30'd0, ctrl_state}, 0);
    tick();

    // Timeout: ready never comes
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      $display("timeout wait %0d: state=%0d fault=%0b", i, ctrl_state, mem_fault);
      check("to_no_early_fault", {31'd0, mem_fault}, 0);
      tick();
    end
    mem_req = 0; #1;
    $display("timeout: fault=%0b state=%0d", mem_fault, ctrl_state);
    check("to_fault", {31'd0, mem_fault}, 1);
    check("to_state", {30'd0, ctrl_state}, 0);
    check("to_stall_count", stall_count, 9);
    tick(); #1;
    check("to_fault_pulse", {31'd0, mem_fault}, 0);
    tick();

    // Simultaneous wait + redirect + load-use
    mem_req = 1; mem_ready = 0; ex_wb_pc = 1;
    ex_mem_command = 5'b01001; ex_reg_d = 7; id_rs1 = 7; id_use_rs1 = 1; #1;
    $display("simul c0: mem_stop=%0b if_bubble=%0b ex_bubble=%0b", mem_stop, if_bubble, ex_bubble);
    check("sim_stop", {31'd0, mem_stop}, 1);
    check("sim_no_if_bubble", {31'd0, if_bubble}, 0);
    check("sim_no_ex_bubble", {31'd0, ex_bubble}, 0);
    tick(); tick();
    mem_ready = 1; #1;
    $display("simul ready: if_bubble=%0b id_bubble=%0b id_stop=%0b", if_bubble, id_bubble, id_stop);
    check("sim_rd_if_bubble", {31'd0, if_bubble}, 1);
    check("sim_rd_id_stop", {31'd0, id_stop}, 0);
    tick();
    ex_wb_pc = 0; mem_req = 0; mem_ready = 0; #1;
    $display("simul flush: state=%0d id_bubble=%0b id_stop=%0b", ctrl_state, id_bubble, id_stop);
    check("sim_flush_state", {30'd0, ctrl_state}, 1);
    check("sim_flush_no_lu", {31'd0, id_stop}, 0);
    check("sim_stall_count", stall_count, 11);
    tick();
    clear_in(); tick();

    // ext_stop freezes FLUSH while stall_count keeps counting
    ex_wb_pc = 1; tick();
    ex_wb_pc = 0; ext_stop = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      $display("ext_stop %0d: state=%0d id_bubble=%0b", i, ctrl_state, id_bubble);
      check("xs_state", {30'd0, ctrl_state}, 1);
      check("xs_no_bubble", {31'd0, id_bubble}, 0);
      tick();
    end
    ext_stop = 0; #1;
    $display("ext_stop released: state=%0d id_bubble=%0b stall_count=%0d", ctrl_state, id_bubble, stall_count);
    check("xs_resume_bubble", {31'd0, id_bubble}, 1);
    check("xs_stall_count", stall_count, 14);
    tick(); #1;
    check("xs_run", {30'd0, ctrl_state}, 0);
    tick();

    // Asynchronous reset in the middle of a wait
    mem_req = 1; mem_ready = 0;
    tick(); tick(); #1;
    $display("pre-reset: state=%0d stall_count=%0d", ctrl_state, stall_count);
    check("ar_pre_state", {30'd0, ctrl_state}, 2);
    check("ar_pre_stall", stall_count, 16);
    #1 rst_n = 1'b0;
    #1;
    $display("async reset: if_stop=%0b state=%0d stall_count=%0d", if_stop, ctrl_state, stall_count);
    check("ar_if_stop", {31'd0, if_stop}, 0);
    check("ar_state", {30'd0, ctrl_state}, 0);
    check("ar_stall", stall_count, 0);
    tick();
    rst_n = 1'b1; clear_in(); #1;
    check("ar_after_state", {30'd0, ctrl_state}, 0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Generates per-stage `stop` (hold) and `bubble` (inject addi x0,x0,0) controls for IF/ID/EX/MEM/WB.
- Handles three conditions: load-use hazards, taken branch/jump/fence redirects from execute, and data-memory wait states with timeout.
- Sits beside the stage registers and drives their `stop`/`bubble` inputs.

Parameters:
- FLUSH_CYCLES, 1: extra ID-bubble cycles after a redirect, covering fetch latency; legal range 0..3.
- MEM_TIMEOUT, 255: max consecutive MEM wait cycles before a fault is raised; legal range 1..255.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  source register 1 of the instruction in ID
- id_rs2  in  5  source register 2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_reg_d  in  5  destination register of the instruction in EX
- ex_mem_command  in  5  MEM command of the EX instruction; bit0 = access, bit1 = write
- ex_wb_pc  in  1  EX redirect request (branch taken, jal/jalr, fence)
- mem_req  in  1  MEM stage has a memory access in flight this cycle
- mem_ready  in  1  memory completes the access this cycle
- ext_stop  in  1  debug/external global pause
- if_stop, id_stop, ex_stop, mem_stop, wb_stop  out  1 each  stage hold
- if_bubble, id_bubble, ex_bubble  out  1 each  stage bubble injection
- mem_fault  out  1  one-cycle pulse on memory timeout
- ctrl_state  out  2  current FSM state
- stall_count  out  32  saturating count of cycles with any `stop` asserted

Behaviour:
- FSM states: RUN = 0, FLUSH = 1, MEM_WAIT = 2; encoding 3 is unused and recovers to RUN.
- Reset (rst_n = 0, asynchronous): state = RUN, flush counter = 0, wait counter = 0, stall_count = 0, mem_fault = 0.
- All stop/bubble outputs are combinational from state and inputs. While rst_n = 0, all stop/bubble outputs are 0.
- load_use = ex_mem_command[0] & ~ex_mem_command[1] & (ex_reg_d != 0) & ((id_use_rs1 & id_rs1 == ex_reg_d) | (id_use_rs2 & id_rs2 == ex_reg_d)).
- mem_wait = mem_req & ~mem_ready.
- Priority, highest first: ext_stop > mem_wait/MEM_WAIT > ex_wb_pc/FLUSH > load_use.
- ext_stop = 1: all five stops = 1, all bubbles = 0. State, counters and stall_count are frozen, except stall_count still increments.
- MEM_WAIT, or mem_wait in RUN/FLUSH:
  - all five stops = 1, bubbles = 0;
  - same cycle, the wait counter loads 1 and state → MEM_WAIT;
  - each further wait cycle increments the counter;
  - mem_ready = 1 → next state RUN, counter clears;
  - counter reaching MEM_TIMEOUT with mem_ready still 0 → mem_fault = 1 for exactly one cycle, next state RUN, counter clears.
  - A redirect pending during a wait is not lost: EX is held, so ex_wb_pc persists and is serviced after the wait.
- ex_wb_pc = 1 in RUN (no wait, no ext_stop):
  - if_bubble = id_bubble = 1 in that cycle;
  - FLUSH_CYCLES = 0 → stay in RUN;
  - otherwise state → FLUSH with flush counter = FLUSH_CYCLES.
- FLUSH: id_bubble = 1, counter decrements each cycle, exit to RUN when it reaches 1. A new ex_wb_pc in FLUSH reloads the counter.
- load_use in RUN, no higher-priority event: if_stop = id_stop = 1, ex_bubble = 1, for one cycle. The next cycle re-evaluates; the load has moved to MEM, so there is no repeat. load_use is ignored in FLUSH, since the ID instruction is being squashed.
- stall_count: +1 on each cycle any stop is 1, saturating at 0xFFFFFFFF.
- No input combination may assert stop and bubble on the same stage simultaneously.

Decomposition:
- Shared package `kasumi_pkg` holds:
  - FSM state localparams (RUN/FLUSH/MEM_WAIT);
  - ex_mem_command bit-index constants (MEMCMD_ACCESS = 0, MEMCMD_WRITE = 1, MEMCMD_F3 = 4:2);
  - ex_command type codes shared with execute.
- One natural sub-module: `hazard_detect`, the purely combinational load_use compare. It is instantiated once and unit-tested separately.

Test Plan:
- Load-use: EX = lw x5 (ex_mem_command = 5'b01001, ex_reg_d = 5), ID uses rs1 = 5 → exactly 1 cycle of if_stop = id_stop = ex_bubble = 1. Repeat with ex_reg_d = 0 or id_use_rs1 = 0 → no stall.
- Redirect with FLUSH_CYCLES = 1: ex_wb_pc pulses 1 cycle → cycle 0: if_bubble = id_bubble = 1; cycle 1: id_bubble = 1, ctrl_state = 1; cycle 2: ctrl_state = 0, outputs 0.
- Memory wait: mem_req = 1, mem_ready low for 3 cycles then high → all stops high for 3 cycles, ctrl_state = 2, stall_count = 3, then RUN.
- Timeout: MEM_TIMEOUT = 4, mem_ready held 0 → mem_fault pulses once after the 4th wait cycle, ctrl_state returns to 0.
- Simultaneous events: mem_wait + ex_wb_pc + load_use in the same cycle → only the stops assert. After mem_ready, the redirect bubbles occur; no load-use stall fires in FLUSH.
- Reset: assert rst_n = 0 mid-MEM_WAIT asynchronously → outputs 0 immediately, ctrl_state = 0, stall_count = 0. ext_stop = 1 freezes the FSM while stall_count keeps incrementing.
